// File: rtl/md_pkg.sv
// Shared op codes, widths and default latencies for the multiply/divide controller.
package md_pkg;

   localparam int unsigned MD_OP_W          = 3;
   localparam int unsigned DATA_W           = 32;
   localparam int unsigned CNT_W            = 4;
   localparam int unsigned MD_MULT_CYCLES   = 5;
   localparam int unsigned MD_DIV_CYCLES    = 10;
   localparam logic [DATA_W-1:0] MD_INT_MIN = 32'h8000_0000;

   typedef enum logic [MD_OP_W-1:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result generator for mult/multu/div/divu, including the
// divide-by-zero and signed-overflow corner cases.
module md_calc
   import md_pkg::*;
(
   input  logic [MD_OP_W-1:0] op,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   output logic [DATA_W-1:0]  res_hi,
   output logic [DATA_W-1:0]  res_lo
);

   logic                  signed_mul;
   logic [DATA_W-1:0]     ext_a;
   logic [DATA_W-1:0]     ext_b;
   logic [2*DATA_W-1:0]   prod;

   // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then exact.
   always_comb begin
      signed_mul = (op == MD_MULT);
      ext_a      = signed_mul ? {DATA_W{a[DATA_W-1]}} : '0;
      ext_b      = signed_mul ? {DATA_W{b[DATA_W-1]}} : '0;
      prod       = {ext_a, a} * {ext_b, b};
   end

   always_comb begin
      res_hi = '0;
      res_lo = '0;
      case (op)
         MD_MULT, MD_MULTU: begin
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
         end
         MD_DIV: begin
            if (b == '0) begin
               res_hi = a;
               res_lo = '1;
            end else if (a == MD_INT_MIN && b == '1) begin
               res_hi = '0;
               res_lo = MD_INT_MIN;
            end else begin
               res_lo = DATA_W'($signed(a) / $signed(b));
               res_hi = DATA_W'($signed(a) % $signed(b));
            end
         end
         MD_DIVU: begin
            if (b == '0) begin
               res_hi = a;
               res_lo = '1;
            end else begin
               res_lo = a / b;
               res_hi = a % b;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, models unit latency with a
// down-counter and raises the hazard stall for HI/LO users.
module md_ctrl
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [MD_OP_W-1:0] op,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   input  logic               e_uses_md,
   output logic               busy,
   output logic               stall,
   output logic [DATA_W-1:0]  hi,
   output logic [DATA_W-1:0]  lo
);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [DATA_W-1:0] phi_q, phi_d, plo_q, plo_d;
   logic [DATA_W-1:0] res_hi, res_lo;
   logic              accept;

   md_calc u_calc (
      .op     (op),
      .a      (a),
      .b      (b),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   assign busy   = (cnt_q != '0);
   assign accept = start & ~busy;

   // Result is computed at acceptance and held until the counter expires.
   always_comb begin
      cnt_d = cnt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      phi_d = phi_q;
      plo_d = plo_q;
      if (accept) begin
         case (op)
            MD_MULT, MD_MULTU: begin
               cnt_d = CNT_W'(MULT_CYCLES);
               phi_d = res_hi;
               plo_d = res_lo;
            end
            MD_DIV, MD_DIVU: begin
               cnt_d = CNT_W'(DIV_CYCLES);
               phi_d = res_hi;
               plo_d = res_lo;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
         endcase
      end else if (busy) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            hi_d = phi_q;
            lo_d = plo_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         phi_q <= '0;
         plo_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         phi_q <= phi_d;
         plo_q <= plo_d;
      end
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign stall = e_uses_md & (busy | start);

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide controller for the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo requests, models the multi-cycle latency of the multiply and divide units, and owns the HI/LO registers.
- Generates the pipeline stall for later HI/LO-using instructions.
- HI/LO outputs feed the E/M and M/W pipeline registers and the mfhi/mflo result path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1-15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1-15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request pulse; op/a/b valid in the same cycle.
- op  in  3  operation code from md_pkg.
- a  in  32  rs operand.
- b  in  32  rt operand.
- e_uses_md  in  1  instruction currently in E reads or writes HI/LO (mult*, div*, mthi, mtlo, mfhi, mflo).
- busy  out  1  unit is executing a multi-cycle operation.
- stall  out  1  stall request to the hazard unit.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (clk edge with reset=1): hi=0, lo=0, busy=0, counter=0, pending results=0. Any in-flight operation is aborted; HI/LO are not updated by it.
- Start acceptance: start is accepted on a rising edge when start=1, busy=0 and reset=0. start while busy=1 is ignored entirely: no state change, no HI/LO write.
- mult/multu/div/divu accepted at edge T:
  - operands latched and the result computed into pending_hi/pending_lo;
  - counter loaded with MULT_CYCLES or DIV_CYCLES.
- busy = (counter != 0). Counter decrements by 1 on each edge while nonzero.
- Commit: on the edge where the counter goes 1 -> 0, hi <= pending_hi and lo <= pending_lo.
  - busy is high for exactly N cycles after edge T.
  - New HI/LO are visible in the first cycle with busy=0.
- mthi/mtlo accepted at edge T: hi <= a (mthi) or lo <= a (mtlo) at edge T; busy stays 0. Single-cycle operation.
- mult: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
- multu: same, unsigned.
- div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
- divu: unsigned.
- Divide by zero (b=0): lo = 32'hFFFF_FFFF, hi = a. Normal busy timing applies.
- Signed overflow 32'h8000_0000 / -1: lo = 32'h8000_0000, hi = 0.
- stall = e_uses_md & (busy | start), purely combinational.
  - This holds the next HI/LO instruction in E for the cycle of start and for all busy cycles.
  - It is released in the cycle busy falls, so mfhi/mflo read committed values.
- Undefined op codes with start=1: no effect, treated as a NOP.
- Simultaneous reset and start: reset wins; the request is dropped.

Decomposition:
- md_pkg holds:
  - op codes: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5;
  - default latency constants.
- Sub-module md_calc: combinational. Takes op, a and b; outputs res_hi, res_lo, including the divide-by-zero and overflow rules. Keeps the arithmetic separately unit-testable.
- md_ctrl contains the counter, pending registers, HI/LO registers and stall logic.

Test Plan:
- Signed mult: start op=MD_MULT a=-3 b=7 -> busy high exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
- Unsigned divide with back-to-back request:
  - start divu a=100 b=7 -> after 10 busy cycles hi=2, lo=14;
  - second start issued during busy cycle 3 -> ignored, HI/LO unchanged by it.
- Stall timing: mflo in E (e_uses_md=1) during a mult.
  - stall=1 in the start cycle and all 5 busy cycles; stall=0 in the cycle busy falls.
  - lo reads the new product in that cycle.
- mthi a=32'h1234_5678 -> hi updated at the next edge, busy never asserts; lo unchanged.
- Edge-case divides:
  - div a=32'h8000_0000 b=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0;
  - divu a=5 b=0 -> lo=32'hFFFF_FFFF, hi=5.
- Reset mid-divide: assert reset in busy cycle 4 -> next cycle busy=0, hi=0, lo=0; no later commit occurs.
